snd_cmd_arbiter: RTL
====================

SND_CMD_ARBITER -- requirements
Module: snd_cmd_arbiter

Interface
REQ-001 SHALL have parameter FIFO_AW, default 2, log2 of the command FIFO depth; used only when SND_CMD_FIFO_EN is defined.
REQ-002 SHALL have port clk  in  1  system clock, 53.6 MHz.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port mcode_wr  in  1  main-CPU sound-command strobe, level; the rising edge is the event.
REQ-005 SHALL have port mcode_din  in  8  command byte, valid while mcode_wr is high.
REQ-006 SHALL have port latch_rd  in  1  sound CPU read of the command port (0xd000), level.
REQ-007 SHALL have port busy_clr  in  1  sound CPU access to 0xe000, level.
REQ-008 SHALL have port mcode_ack  in  1  sound CPU access to 0xf004, level.
REQ-009 SHALL have port ym_irq  in  1  YM3526 interrupt, active-high, level.
REQ-010 SHALL have port ym_ack  in  1  sound CPU access to 0xf006, level.
REQ-011 SHALL have port cmd_dout  out  8  command byte to the sound CPU data mux.
REQ-012 SHALL have port snd_busy  out  1  busy flag to the main CPU.
REQ-013 SHALL have port int_n  out  1  Z80 INT, active-low.
REQ-014 SHALL have port irq_src  out  2  pending sources: bit1 = YM, bit0 = command.
REQ-015 SHALL have port ovf  out  1  sticky flag, set when a command is dropped.

Function
REQ-016 SHALL detect each event from a registered copy of its input, registered in the same cycle; an event is old=0 and new=1.
REQ-017 SHALL run a command FSM with states EMPTY, PEND and ACKED; the reset state SHALL be EMPTY.
- EMPTY to PEND: on an accepted mcode event.
- PEND to ACKED: on a mcode_ack event.
- ACKED or PEND to EMPTY: on a busy_clr event.
- ACKED to PEND: on an accepted mcode event, or on mcode_ack while entries remain queued.
REQ-018 SHALL assert irq_src[0] exactly in state PEND.
REQ-019 SHALL set snd_busy on an accepted mcode event and clear it on a busy_clr event; if both events occur in the same cycle, set SHALL win and the FSM SHALL go to PEND.
REQ-020 SHALL set irq_src[1] on a ym_irq event and clear it on a ym_ack event; if both occur in the same cycle, set SHALL win.
REQ-021 SHALL drive int_n registered as ~|irq_src, with one clk of latency after irq_src changes.
REQ-022 SHALL drive cmd_dout registered: the head command the cycle after latch_rd is high, and 8'hFF otherwise.
REQ-023 SHALL capture mcode_din in the same cycle as the mcode event.
REQ-024 SHALL ignore ack, clear and read inputs that arrive while the FSM is in a state where they have no effect (for example, mcode_ack in EMPTY is a no-op).

Reset
REQ-025 SHALL, while rst is high, hold: FSM=EMPTY, cmd register and FIFO=00 and empty, snd_busy=0, irq_src=00, int_n=1, cmd_dout=FF, ovf=0, edge registers=0.
REQ-026 SHALL, when reset is asserted mid-operation, discard pending commands and interrupts within one clk with no partial state; inputs already high when rst falls SHALL NOT produce events.

Configuration
REQ-027 SHALL implement, when SND_CMD_FIFO_EN is undefined, a single command register:
- every mcode event is accepted and overwrites the register;
- a busy_clr event zeroes the register (74273 clear);
- ovf is tied to 0.
REQ-028 SHALL implement, when SND_CMD_FIFO_EN is defined, a 2^FIFO_AW-entry FIFO:
- an mcode event pushes when not full; when full, it is dropped and sets ovf;
- a falling edge of latch_rd pops when not empty;
- a mcode_ack event with count>1 after the pop returns the FSM to PEND;
- a busy_clr event flushes the FIFO;
- read and write pointers wrap modulo depth; simultaneous push and pop keep the count unchanged.

Verification
REQ-029 SHALL cover: mcode event with 8'h5A -> snd_busy=1 and int_n=0 two cycles later; latch_rd held high -> cmd_dout=5A; mcode_ack -> int_n=1; busy_clr -> snd_busy=0.
REQ-030 SHALL cover: ym_irq rising together with a pending command -> irq_src=11; ym_ack -> irq_src=01 and int_n stays 0.
REQ-031 SHALL cover: busy_clr and mcode events in the same cycle -> snd_busy=1, FSM=PEND.
REQ-032 SHALL cover, with FIFO and FIFO_AW=2: 5 commands 01..05 -> ovf=1; reads return 01..04 in order; 05 is lost.
REQ-033 SHALL cover, without FIFO: commands 11 then 22 -> cmd_dout=22; busy_clr then read -> 00.
REQ-034 SHALL cover: rst pulsed while in PEND with mcode_wr held high -> all outputs at reset values and no event after release.

Source files
------------

// File: rtl/snd_cmd_arbiter.sv
// snd_cmd_arbiter: sound-command latch (or FIFO) plus Z80 interrupt arbitration.
// Build option: define SND_CMD_FIFO_EN to replace the single command register with a FIFO.
//
// state | meaning
// EMPTY | no command outstanding
// PEND  | command waiting for the sound CPU, drives irq_src[0]
// ACKED | sound CPU acknowledged, busy held until the 0xe000 access
module snd_cmd_arbiter #(
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mcode_wr,
  input  logic [7:0] mcode_din,
  input  logic       latch_rd,
  input  logic       busy_clr,
  input  logic       mcode_ack,
  input  logic       ym_irq,
  input  logic       ym_ack,
  output logic [7:0] cmd_dout,
  output logic       snd_busy,
  output logic       int_n,
  output logic [1:0] irq_src,
  output logic       ovf
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_ACKED = 2'd2;

  logic             r_armed;
  logic             r_mcode_wr_d, r_busy_clr_d, r_mcode_ack_d, r_ym_irq_d, r_ym_ack_d;
  logic             w_mc_ev, w_clr_ev, w_ack_ev, w_ymi_ev, w_yma_ev, w_mc_acc;
  logic [1:0]       r_state, w_state_nxt;
  logic             r_busy, r_ym_pend, r_int_n;
  logic [7:0]       r_cmd_dout, w_head;
  logic [FIFO_AW:0] w_count;

  // r_armed masks the first cycle after reset so levels already high never look like edges
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed       <= 1'b0;
      r_mcode_wr_d  <= 1'b0;
      r_busy_clr_d  <= 1'b0;
      r_mcode_ack_d <= 1'b0;
      r_ym_irq_d    <= 1'b0;
      r_ym_ack_d    <= 1'b0;
    end else begin
      r_armed       <= 1'b1;
      r_mcode_wr_d  <= mcode_wr;
      r_busy_clr_d  <= busy_clr;
      r_mcode_ack_d <= mcode_ack;
      r_ym_irq_d    <= ym_irq;
      r_ym_ack_d    <= ym_ack;
    end
  end

  assign w_mc_ev  = r_armed & mcode_wr  & ~r_mcode_wr_d;
  assign w_clr_ev = r_armed & busy_clr  & ~r_busy_clr_d;
  assign w_ack_ev = r_armed & mcode_ack & ~r_mcode_ack_d;
  assign w_ymi_ev = r_armed & ym_irq    & ~r_ym_irq_d;
  assign w_yma_ev = r_armed & ym_ack    & ~r_ym_ack_d;

`ifdef SND_CMD_FIFO_EN
  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0]   r_count;
  logic               r_latch_rd_d, r_ovf;
  logic               w_full, w_empty, w_pop;

  assign w_full   = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  // a clear in the same cycle flushes first, so the new command always fits
  assign w_mc_acc = w_mc_ev & (~w_full | w_clr_ev);
  assign w_pop    = r_armed & r_latch_rd_d & ~latch_rd & ~w_empty & ~w_clr_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_latch_rd_d <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_latch_rd_d <= latch_rd;
      if (w_mc_ev & w_full & ~w_clr_ev) r_ovf <= 1'b1;
      if (w_clr_ev) begin
        r_rp <= '0;
        if (w_mc_acc) begin
          r_mem[0] <= mcode_din;
          r_wp     <= FIFO_AW'(1);
          r_count  <= (FIFO_AW+1)'(1);
        end else begin
          r_wp     <= '0;
          r_count  <= '0;
        end
      end else begin
        if (w_mc_acc) begin
          r_mem[r_wp] <= mcode_din;
          r_wp        <= r_wp + 1'b1;
        end
        if (w_pop) r_rp <= r_rp + 1'b1;
        case ({w_mc_acc, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign w_head  = w_empty ? 8'h00 : r_mem[r_rp];
  assign w_count = r_count;
  assign ovf     = r_ovf;
`else
  logic [7:0] r_cmd;

  assign w_mc_acc = w_mc_ev;

  always_ff @(posedge clk) begin
    if (rst)           r_cmd <= '0;
    else if (w_mc_ev)  r_cmd <= mcode_din;
    else if (w_clr_ev) r_cmd <= '0;
  end

  assign w_head  = r_cmd;
  assign w_count = (r_state != ST_EMPTY) ? (FIFO_AW+1)'(1) : '0;
  assign ovf     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (w_mc_acc) begin
      w_state_nxt = ST_PEND;
    end else begin
      case (r_state)
        ST_EMPTY: w_state_nxt = ST_EMPTY;
        ST_PEND: begin
          if (w_clr_ev)      w_state_nxt = ST_EMPTY;
          else if (w_ack_ev) w_state_nxt = ST_ACKED;
        end
        ST_ACKED: begin
          if (w_clr_ev)                                    w_state_nxt = ST_EMPTY;
          else if (w_ack_ev && w_count > (FIFO_AW+1)'(1))  w_state_nxt = ST_PEND;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_busy     <= 1'b0;
      r_ym_pend  <= 1'b0;
      r_int_n    <= 1'b1;
      r_cmd_dout <= 8'hFF;
    end else begin
      r_state <= w_state_nxt;
      if (w_mc_acc)      r_busy <= 1'b1;
      else if (w_clr_ev) r_busy <= 1'b0;
      if (w_ymi_ev)      r_ym_pend <= 1'b1;
      else if (w_yma_ev) r_ym_pend <= 1'b0;
      r_int_n    <= ~|irq_src;
      r_cmd_dout <= latch_rd ? w_head : 8'hFF;
    end
  end

  assign irq_src  = {r_ym_pend, (r_state == ST_PEND)};
  assign snd_busy = r_busy;
  assign int_n    = r_int_n;
  assign cmd_dout = r_cmd_dout;

endmodule
